// File: rtl/udp_rx_parser_pkg.sv
// Shared types and constants for the UDP receive parser.
package udp_rx_parser_pkg;

  localparam int unsigned UDP_HDR_LEN  = 8;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

  typedef enum logic [1:0] {StIdle, StHdr, StData, StWaitEnd} udp_rx_parse_state;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       last;
  } axi_in_type;

  typedef struct packed {
    logic        is_valid;
    logic [7:0]  protocol;
    logic [15:0] data_length;
    logic [31:0] src_ip_addr;
  } ipv4_rx_header_type;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] src_ip_addr;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_rx_header_type;

endpackage

// File: rtl/udp_rx_parser_if.sv
// IPv4-RX-side inputs and UDP-RX-side outputs of the parser; master is the upstream/stimulus side.
interface udp_rx_parser_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ip_rx_start;
  logic             ip_rx_is_valid;
  logic [7:0]       ip_rx_protocol;
  logic [15:0]      ip_rx_data_length;
  logic [31:0]      ip_rx_src_ip_addr;
  logic [7:0]       ip_rx_data_in;
  logic             ip_rx_data_in_valid;
  logic             ip_rx_data_in_last;
  logic             udp_rx_start;
  logic             udp_rx_is_valid;
  logic [31:0]      udp_rx_src_ip_addr;
  logic [15:0]      udp_rx_src_port;
  logic [15:0]      udp_rx_dst_port;
  logic [15:0]      udp_rx_data_length;
  logic [7:0]       udp_rx_data_in;
  logic             udp_rx_data_in_valid;
  logic             udp_rx_data_in_last;
  logic [CNT_W-1:0] udp_rx_pkt_count;
  logic [CNT_W-1:0] udp_rx_err_count;

  modport master (
    output ip_rx_start, ip_rx_is_valid, ip_rx_protocol, ip_rx_data_length, ip_rx_src_ip_addr,
           ip_rx_data_in, ip_rx_data_in_valid, ip_rx_data_in_last,
    input  udp_rx_start, udp_rx_is_valid, udp_rx_src_ip_addr, udp_rx_src_port, udp_rx_dst_port,
           udp_rx_data_length, udp_rx_data_in, udp_rx_data_in_valid, udp_rx_data_in_last,
           udp_rx_pkt_count, udp_rx_err_count
  );

  modport slave (
    input  ip_rx_start, ip_rx_is_valid, ip_rx_protocol, ip_rx_data_length, ip_rx_src_ip_addr,
           ip_rx_data_in, ip_rx_data_in_valid, ip_rx_data_in_last,
    output udp_rx_start, udp_rx_is_valid, udp_rx_src_ip_addr, udp_rx_src_port, udp_rx_dst_port,
           udp_rx_data_length, udp_rx_data_in, udp_rx_data_in_valid, udp_rx_data_in_last,
           udp_rx_pkt_count, udp_rx_err_count
  );
endinterface

// File: rtl/udp_rx_parser_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module udp_rx_parser_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             srst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);
  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + Width'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/udp_rx_parser.sv
// Strips the 8-byte UDP header from the IPv4 payload stream and forwards the UDP payload
// one cycle later, with header outputs and good/error packet statistics.
module udp_rx_parser
  import udp_rx_parser_pkg::*;
#(
  parameter logic [7:0]  UDP_PROTOCOL = IP_PROTO_UDP,
  parameter int unsigned CNT_W        = 8
) (
  input logic            clk,
  input logic            rst_n,
  udp_rx_parser_if.slave bus
);
  localparam logic [15:0] HdrLen = 16'(UDP_HDR_LEN);

  udp_rx_parse_state state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] ip_len_q, ip_len_d, rem_q, rem_d;
  logic [31:0] cap_ip_q, cap_ip_d;
  logic [15:0] cap_sp_q, cap_sp_d, cap_dp_q, cap_dp_d, cap_len_q, cap_len_d;
  logic        start_q, start_d, hv_q, hv_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] sp_q, sp_d, dp_q, dp_d, dlen_q, dlen_d;
  logic [7:0]  dout_q, dout_d;
  logic        dval_q, dval_d, dlast_q, dlast_d;
  logic        pkt_inc, err_inc;
  logic        in_v, in_l;

  assign in_v = bus.ip_rx_data_in_valid;
  assign in_l = bus.ip_rx_data_in_last;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ip_len_d  = ip_len_q;
    rem_d     = rem_q;
    cap_ip_d  = cap_ip_q;
    cap_sp_d  = cap_sp_q;
    cap_dp_d  = cap_dp_q;
    cap_len_d = cap_len_q;
    start_d   = 1'b0;
    hv_d      = hv_q;
    ip_d      = ip_q;
    sp_d      = sp_q;
    dp_d      = dp_q;
    dlen_d    = dlen_q;
    dout_d    = dout_q;
    dval_d    = 1'b0;
    dlast_d   = 1'b0;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.ip_rx_start) begin
          if (bus.ip_rx_is_valid && (bus.ip_rx_protocol == UDP_PROTOCOL)) begin
            cap_ip_d = bus.ip_rx_src_ip_addr;
            ip_len_d = bus.ip_rx_data_length;
            idx_d    = 3'd0;
            state_d  = StHdr;
          end else begin
            state_d = StWaitEnd;
          end
        end else if (in_v && !in_l) begin
          // Orphan bytes (e.g. after a mid-packet reset) are skipped to the packet end.
          state_d = StWaitEnd;
        end
      end
      StHdr: begin
        if (in_v) begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0:    cap_sp_d[15:8]  = bus.ip_rx_data_in;
            3'd1:    cap_sp_d[7:0]   = bus.ip_rx_data_in;
            3'd2:    cap_dp_d[15:8]  = bus.ip_rx_data_in;
            3'd3:    cap_dp_d[7:0]   = bus.ip_rx_data_in;
            3'd4:    cap_len_d[15:8] = bus.ip_rx_data_in;
            3'd5:    cap_len_d[7:0]  = bus.ip_rx_data_in;
            default: ;
          endcase
          if (idx_q == 3'd7) begin
            // len > ip_len is the underflow-safe form of (len-8) > (ip_len-8) once len >= 8.
            if ((cap_len_q < HdrLen) || (cap_len_q > ip_len_q) ||
                (in_l && (cap_len_q != HdrLen))) begin
              err_inc = 1'b1;
              hv_d    = 1'b0;
              state_d = in_l ? StIdle : StWaitEnd;
            end else begin
              start_d = 1'b1;
              hv_d    = 1'b1;
              ip_d    = cap_ip_q;
              sp_d    = cap_sp_q;
              dp_d    = cap_dp_q;
              dlen_d  = cap_len_q - HdrLen;
              rem_d   = cap_len_q - HdrLen;
              if (cap_len_q == HdrLen) begin
                pkt_inc = 1'b1;
                state_d = in_l ? StIdle : StWaitEnd;
              end else begin
                state_d = StData;
              end
            end
          end else if (in_l) begin
            err_inc = 1'b1;
            hv_d    = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (in_v) begin
          dout_d = bus.ip_rx_data_in;
          dval_d = 1'b1;
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            dlast_d = 1'b1;
            pkt_inc = 1'b1;
            state_d = in_l ? StIdle : StWaitEnd;
          end else if (in_l) begin
            dlast_d = 1'b1;
            err_inc = 1'b1;
            hv_d    = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StWaitEnd: begin
        if (in_v && in_l) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ip_len_q  <= '0;
      rem_q     <= '0;
      cap_ip_q  <= '0;
      cap_sp_q  <= '0;
      cap_dp_q  <= '0;
      cap_len_q <= '0;
      start_q   <= 1'b0;
      hv_q      <= 1'b0;
      ip_q      <= '0;
      sp_q      <= '0;
      dp_q      <= '0;
      dlen_q    <= '0;
      dout_q    <= '0;
      dval_q    <= 1'b0;
      dlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ip_len_q  <= ip_len_d;
      rem_q     <= rem_d;
      cap_ip_q  <= cap_ip_d;
      cap_sp_q  <= cap_sp_d;
      cap_dp_q  <= cap_dp_d;
      cap_len_q <= cap_len_d;
      start_q   <= start_d;
      hv_q      <= hv_d;
      ip_q      <= ip_d;
      sp_q      <= sp_d;
      dp_q      <= dp_d;
      dlen_q    <= dlen_d;
      dout_q    <= dout_d;
      dval_q    <= dval_d;
      dlast_q   <= dlast_d;
    end
  end

  udp_rx_parser_sat_counter #(.Width(CNT_W)) u_pkt_cnt (
    .clk_i   (clk),
    .srst_ni (rst_n),
    .inc_i   (pkt_inc),
    .count_o (bus.udp_rx_pkt_count)
  );

  udp_rx_parser_sat_counter #(.Width(CNT_W)) u_err_cnt (
    .clk_i   (clk),
    .srst_ni (rst_n),
    .inc_i   (err_inc),
    .count_o (bus.udp_rx_err_count)
  );

  assign bus.udp_rx_start         = start_q;
  assign bus.udp_rx_is_valid      = hv_q;
  assign bus.udp_rx_src_ip_addr   = ip_q;
  assign bus.udp_rx_src_port      = sp_q;
  assign bus.udp_rx_dst_port      = dp_q;
  assign bus.udp_rx_data_length   = dlen_q;
  assign bus.udp_rx_data_in       = dout_q;
  assign bus.udp_rx_data_in_valid = dval_q;
  assign bus.udp_rx_data_in_last  = dlast_q;
endmodule

// File: tb/tb_udp_rx_parser.sv
// Bench for udp_rx_parser: directed packets plus random packets against a packet-level model.
module tb_udp_rx_parser;
  import udp_rx_parser_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_rx_parser_if #(.CNT_W(8)) bus ();

  udp_rx_parser #(.UDP_PROTOCOL(IP_PROTO_UDP), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Monitor state
  axi_in_type  ob[$];
  int          oc[$];
  int          st_n = 0;
  int          st_cyc = 0;
  logic [31:0] st_ip;
  logic [15:0] st_sp, st_dp, st_dl;

  // Stimulus state
  logic [7:0]  pkt[$];
  int          dcyc[$];
  logic [7:0]  g_proto;
  bit          g_isval;
  logic [15:0] g_iplen;
  logic [31:0] g_ip;

  // Model state
  int exp_pkt = 0;
  int exp_err = 0;
  bit exp_hv = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.udp_rx_start) begin
      st_n++;
      st_cyc = cyc;
      st_ip  = bus.udp_rx_src_ip_addr;
      st_sp  = bus.udp_rx_src_port;
      st_dp  = bus.udp_rx_dst_port;
      st_dl  = bus.udp_rx_data_length;
    end
    if (bus.udp_rx_data_in_valid) begin
      ob.push_back('{data: bus.udp_rx_data_in, valid: 1'b1, last: bus.udp_rx_data_in_last});
      oc.push_back(cyc);
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_start"}, 32'(bus.udp_rx_start), 0);
    chk({tag, "_hv"}, 32'(bus.udp_rx_is_valid), 0);
    chk({tag, "_ip"}, bus.udp_rx_src_ip_addr, 0);
    chk({tag, "_sp"}, 32'(bus.udp_rx_src_port), 0);
    chk({tag, "_dp"}, 32'(bus.udp_rx_dst_port), 0);
    chk({tag, "_dlen"}, 32'(bus.udp_rx_data_length), 0);
    chk({tag, "_data"}, 32'(bus.udp_rx_data_in), 0);
    chk({tag, "_dval"}, 32'(bus.udp_rx_data_in_valid), 0);
    chk({tag, "_dlast"}, 32'(bus.udp_rx_data_in_last), 0);
    chk({tag, "_pkt"}, 32'(bus.udp_rx_pkt_count), 0);
    chk({tag, "_err"}, 32'(bus.udp_rx_err_count), 0);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bus.ip_rx_start = 1'b0;
      bus.ip_rx_data_in_valid = 1'b0;
      bus.ip_rx_data_in_last = 1'b0;
    end
  endtask

  task automatic put_start();
    @(negedge clk);
    bus.ip_rx_start = 1'b1;
    bus.ip_rx_is_valid = g_isval;
    bus.ip_rx_protocol = g_proto;
    bus.ip_rx_data_length = g_iplen;
    bus.ip_rx_src_ip_addr = g_ip;
    bus.ip_rx_data_in_valid = 1'b0;
    bus.ip_rx_data_in_last = 1'b0;
  endtask

  task automatic put_byte(logic [7:0] b, logic l, bit gaps);
    if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2));
    @(negedge clk);
    bus.ip_rx_start = 1'b0;
    bus.ip_rx_data_in = b;
    bus.ip_rx_data_in_valid = 1'b1;
    bus.ip_rx_data_in_last = l;
    dcyc.push_back(cyc);
  endtask

  task automatic mk_udp(logic [15:0] sp, logic [15:0] dp, logic [15:0] lenf, int pay, int pad);
    pkt.delete();
    pkt.push_back(sp[15:8]);   pkt.push_back(sp[7:0]);
    pkt.push_back(dp[15:8]);   pkt.push_back(dp[7:0]);
    pkt.push_back(lenf[15:8]); pkt.push_back(lenf[7:0]);
    pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom));
    for (int i = 0; i < pay + pad; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic send(logic [7:0] proto, bit isval, logic [15:0] iplen, bit gaps);
    g_proto = proto;
    g_isval = isval;
    g_iplen = iplen;
    g_ip    = $urandom;
    ob.delete(); oc.delete(); dcyc.delete();
    st_n = 0;
    put_start();
    for (int i = 0; i < pkt.size(); i++) put_byte(pkt[i], i == pkt.size() - 1, gaps);
    idle(4);
  endtask

  function automatic void bump_err();
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    exp_hv  = 0;
  endfunction

  function automatic void bump_pkt();
    exp_pkt = (exp_pkt == 255) ? 255 : exp_pkt + 1;
  endfunction

  // Packet-level model: what the user side should see for the packet just sent.
  task automatic check_pkt(string tag);
    int          n, pay;
    logic [15:0] len;
    bit          exp_st;
    logic [7:0]  eb[$];
    bit          el[$];
    int          ei[$];
    n = pkt.size();
    exp_st = 0;
    if (g_isval && (g_proto == 8'h11)) begin
      if (n < 8) begin
        bump_err();
      end else begin
        len = {pkt[4], pkt[5]};
        pay = int'(len) - 8;
        if ((len < 16'd8) || (len > g_iplen) || ((n == 8) && (pay > 0))) begin
          bump_err();
        end else begin
          exp_st = 1;
          exp_hv = 1;
          for (int i = 0; (i < pay) && (8 + i < n); i++) begin
            eb.push_back(pkt[8 + i]);
            el.push_back(0);
            ei.push_back(8 + i);
          end
          if (eb.size() > 0) el[eb.size() - 1] = 1;
          if (8 + pay <= n) bump_pkt();
          else bump_err();
        end
      end
    end
    chk({tag, "_starts"}, 32'(st_n), exp_st ? 1 : 0);
    if (exp_st) begin
      chk({tag, "_src_ip"}, st_ip, g_ip);
      chk({tag, "_src_port"}, 32'(st_sp), 32'({pkt[0], pkt[1]}));
      chk({tag, "_dst_port"}, 32'(st_dp), 32'({pkt[2], pkt[3]}));
      chk({tag, "_dlen"}, 32'(st_dl), 32'({pkt[4], pkt[5]}) - 8);
      if (ob.size() > 0) chk({tag, "_start_lead"}, 32'(st_cyc < oc[0]), 1);
    end
    chk({tag, "_nbytes"}, 32'(ob.size()), 32'(eb.size()));
    for (int i = 0; (i < ob.size()) && (i < eb.size()); i++) begin
      chk($sformatf("%s_b%0d_data", tag, i), 32'(ob[i].data), 32'(eb[i]));
      chk($sformatf("%s_b%0d_last", tag, i), 32'(ob[i].last), 32'(el[i]));
      chk($sformatf("%s_b%0d_lat", tag, i), 32'(oc[i]), 32'(dcyc[ei[i]] + 1));
    end
    chk({tag, "_pkt_count"}, 32'(bus.udp_rx_pkt_count), 32'(exp_pkt));
    chk({tag, "_err_count"}, 32'(bus.udp_rx_err_count), 32'(exp_err));
    chk({tag, "_is_valid"}, 32'(bus.udp_rx_is_valid), 32'(exp_hv));
  endtask

  initial begin
    int          kind, pay, pad, keep;
    logic [15:0] lenf, iplen;
    logic [7:0]  proto;
    bit          isval;
    bus.ip_rx_start = 0; bus.ip_rx_is_valid = 0; bus.ip_rx_protocol = 0;
    bus.ip_rx_data_length = 0; bus.ip_rx_src_ip_addr = 0; bus.ip_rx_data_in = 0;
    bus.ip_rx_data_in_valid = 0; bus.ip_rx_data_in_last = 0;
    rst_n = 1'b0;
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Basic packet: exact IP length
    mk_udp(16'h04D2, 16'h0035, 16'h000C, 4, 0);
    pkt[8] = 8'hAA; pkt[9] = 8'hBB; pkt[10] = 8'hCC; pkt[11] = 8'hDD;
    send(8'd17, 1, 16'd12, 0);
    chk("t1_src_port", 32'(st_sp), 32'h04D2);
    chk("t1_dst_port", 32'(st_dp), 32'h0035);
    chk("t1_dlen", 32'(st_dl), 4);
    if (ob.size() == 4) chk("t1_last_byte", 32'({ob[3].data, ob[3].last}), 32'h1BB);
    else chk("t1_count", 32'(ob.size()), 4);
    check_pkt("t1");

    // Same packet followed by IP padding
    mk_udp(16'h04D2, 16'h0035, 16'h000C, 4, 4);
    pkt[8] = 8'hAA; pkt[9] = 8'hBB; pkt[10] = 8'hCC; pkt[11] = 8'hDD;
    send(8'd17, 1, 16'd16, 0);
    check_pkt("t2");

    // UDP length below header size
    mk_udp(16'h1111, 16'h2222, 16'h0006, 4, 0);
    send(8'd17, 1, 16'd12, 0);
    check_pkt("t3");
    chk("t3_hv_low", 32'(bus.udp_rx_is_valid), 0);

    // Truncated payload
    mk_udp(16'h3333, 16'h4444, 16'h0010, 3, 0);
    send(8'd17, 1, 16'd16, 0);
    check_pkt("t4");

    // TCP then UDP back-to-back
    mk_udp(16'h5555, 16'h6666, 16'h000A, 2, 0);
    send(8'd6, 1, 16'd10, 0);
    check_pkt("t5a");
    mk_udp(16'h7777, 16'h8888, 16'h000B, 3, 0);
    send(8'd17, 1, 16'd11, 0);
    check_pkt("t5b");

    // Reset in the middle of the payload
    mk_udp(16'h9999, 16'hAAAA, 16'h000C, 4, 4);
    g_proto = 8'd17; g_isval = 1; g_iplen = 16'd16; g_ip = $urandom;
    put_start();
    for (int i = 0; i < 10; i++) put_byte(pkt[i], 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.ip_rx_data_in = pkt[10];
    @(negedge clk);
    rst_n = 1'b1;
    bus.ip_rx_data_in_valid = 1'b0;
    chk_zero("t6_rst");
    exp_pkt = 0; exp_err = 0; exp_hv = 0;
    ob.delete(); oc.delete(); st_n = 0;
    for (int i = 11; i < 16; i++) put_byte(pkt[i], i == 15, 0);
    idle(4);
    chk("t6_no_start", 32'(st_n), 0);
    chk("t6_no_bytes", 32'(ob.size()), 0);
    chk("t6_pkt_count", 32'(bus.udp_rx_pkt_count), 0);
    chk("t6_err_count", 32'(bus.udp_rx_err_count), 0);
    mk_udp(16'hBBBB, 16'hCCCC, 16'h000D, 5, 0);
    send(8'd17, 1, 16'd13, 0);
    check_pkt("t6b");

    // Random packets with input gaps
    for (int k = 0; k < 150; k++) begin
      kind  = $urandom_range(0, 9);
      pay   = $urandom_range(0, 10);
      pad   = 0;
      proto = 8'd17;
      isval = 1;
      if (kind == 2) pad = $urandom_range(1, 5);
      if (kind == 5) pay = $urandom_range(2, 10);
      lenf  = 16'(8 + pay);
      iplen = 16'(8 + pay + pad);
      mk_udp(16'($urandom), 16'($urandom), lenf, pay, pad);
      case (kind)
        0: proto = 8'(6 + 2 * $urandom_range(0, 3));
        1: isval = 0;
        3: begin pkt[4] = 8'h00; pkt[5] = 8'($urandom_range(0, 7)); end
        4: begin
          lenf = iplen + 16'($urandom_range(1, 4));
          pkt[4] = lenf[15:8];
          pkt[5] = lenf[7:0];
        end
        5: begin
          keep = 8 + $urandom_range(1, pay - 1);
          while (pkt.size() > keep) void'(pkt.pop_back());
        end
        6: begin
          keep = $urandom_range(1, 7);
          while (pkt.size() > keep) void'(pkt.pop_back());
        end
        default: ;
      endcase
      send(proto, isval, iplen, 1);
      check_pkt($sformatf("rnd%0d", k));
    end

    // Counter saturation
    for (int k = 0; k < 260; k++) begin
      mk_udp(16'($urandom), 16'($urandom), 16'd8, 0, 0);
      send(8'd17, 1, 16'd8, 0);
      check_pkt("sat_pkt");
    end
    for (int k = 0; k < 260; k++) begin
      mk_udp(16'($urandom), 16'($urandom), 16'd4, 0, 0);
      send(8'd17, 1, 16'd8, 0);
      check_pkt("sat_err");
    end
    chk("sat_pkt_final", 32'(bus.udp_rx_pkt_count), 32'hFF);
    chk("sat_err_final", 32'(bus.udp_rx_err_count), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Receive-side counterpart of the UDP TX path. Consumes the byte stream and header delivered by the IPv4 RX layer.
- Decodes and strips the 8-byte UDP header, then forwards the UDP payload with a populated UDP RX header to the user side.
- Sits between the IPv4 RX block and the user application. No backpressure; this matches the valid/last-only AXI structs.

Parameters:
UDP_PROTOCOL, 8'h11, IPv4 protocol number accepted; packets with any other protocol are ignored.
CNT_W, 8, width of the saturating statistics counters.

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  reset, synchronous and active-low
ip_rx_start  in  1  one-cycle pulse; IPv4 header fields are valid this cycle
ip_rx_is_valid  in  1  IPv4 header is valid
ip_rx_protocol  in  8  IPv4 protocol field
ip_rx_data_length  in  16  IPv4 payload length in bytes
ip_rx_src_ip_addr  in  32  source IP address
ip_rx_data_in  in  8  payload byte
ip_rx_data_in_valid  in  1  byte qualifier
ip_rx_data_in_last  in  1  final IPv4 payload byte
udp_rx_start  out  1  one-cycle pulse when the UDP header outputs become valid
udp_rx_is_valid  out  1  header valid, held until next start or error
udp_rx_src_ip_addr  out  32  copied from IPv4 header
udp_rx_src_port  out  16  UDP source port
udp_rx_dst_port  out  16  UDP destination port
udp_rx_data_length  out  16  UDP length minus 8
udp_rx_data_in  out  8  payload byte
udp_rx_data_in_valid  out  1  payload qualifier
udp_rx_data_in_last  out  1  final payload byte
udp_rx_pkt_count  out  CNT_W  good packets (saturating)
udp_rx_err_count  out  CNT_W  dropped/truncated packets (saturating)

Behaviour:
- Reset: rst_n low at a clock edge forces all outputs to 0 and the state to IDLE, including mid-packet. The remainder of the interrupted packet is skipped via WAIT_END.
  - IDLE entered after reset does not require a fresh ip_rx_start if bytes are arriving. Any valid byte seen without a prior start is discarded until ip_rx_data_in_last.
- States: IDLE, HDR, DATA, WAIT_END.
- IDLE:
  - On ip_rx_start with is_valid=1 and protocol==UDP_PROTOCOL: latch src_ip, clear byte index, go to HDR.
  - Start with another protocol or is_valid=0: go to WAIT_END, with no counter change.
- HDR: byte index 0..7, in network order:
  - Bytes 0-1: src_port. Bytes 2-3: dst_port. Bytes 4-5: UDP length. Bytes 6-7: checksum (not checked).
  - On byte 7:
    - If length < 8 or length-8 > ip_rx_data_length-8: drop, err_count+1, go to WAIT_END (or IDLE if last).
    - Otherwise, next cycle: udp_rx_start=1, is_valid=1, data_length=length-8, go to DATA.
    - If length==8: also pkt_count+1; go to IDLE if last, else WAIT_END.
  - Last asserted before byte 7: drop silently apart from err_count+1, no start pulse, go to IDLE.
- DATA:
  - Each input byte is forwarded with exactly 1 cycle latency, with a remaining-byte counter.
  - udp_rx_data_in_last=1 on the byte where remaining reaches 0. pkt_count+1 there. Then IDLE if input last coincides, else WAIT_END, which discards IP padding.
  - Input last before remaining reaches 0 (truncated): emit that byte with last=1, err_count+1, no pkt_count, go to IDLE.
- WAIT_END: discard bytes until ip_rx_data_in_last, then IDLE. An ip_rx_start seen in WAIT_END is ignored.
- udp_rx_start precedes the first payload valid by at least 1 cycle.
- Header outputs are stable from start until the next start.
- udp_rx_is_valid is cleared on the error path.
- Counters saturate at all-ones.
- All length arithmetic is 16-bit unsigned; underflow is checked before the subtraction.
- Gaps in ip_rx_data_in_valid are allowed in every state.

Decomposition:
- Shared global types package receives:
  - udp_rx_parse_state enum (IDLE, HDR, DATA, WAIT_END).
  - UDP_HDR_LEN=8.
  - IP_PROTO_UDP=8'h11.
- Existing udp_rx_header_type, axi_in_type and ipv4_rx_header_type are reused by the bench.
- One sub-module is natural: sat_counter (width-parameterised saturating increment), instantiated twice.

Test Plan:
- Proto 17, IP length 12, header bytes 04 D2 00 35 00 0C 00 00, payload AA BB CC DD -> start pulse; src_port 0x04D2, dst_port 0x0035, data_length 4; 4 bytes out 1 cycle late, last on DD; pkt_count=1.
- Same packet with IP length 16 (4 padding bytes) -> 4 payload bytes out, last on DD, padding discarded, pkt_count=1, err_count=0.
- UDP length field 0x0006 -> no start pulse, no data, err_count=1, is_valid=0.
- UDP length 0x0010 but ip last after 3 payload bytes -> 3 bytes out, last on 3rd, err_count=1, pkt_count unchanged.
- Protocol 6 (TCP) packet, then a valid UDP packet back-to-back -> first ignored with no outputs; second parsed normally.
- rst_n low for 1 cycle during DATA -> all outputs 0 next cycle; remaining bytes discarded; next packet parsed correctly.
